gelu_row_packer: RTL and testbench

Upstream feeder for the GELU stage. Accepts activation rows one per handshake (`DIMENTION` signed `x_WIDTH`-bit elements per row) and assembles `GELU_NUM` rows into the flat tensor. It issues the tensor to the GELU stage with a one-cycle active-low `input_valid_n` pulse, then holds the tensor stable until the stage returns `gelu_valid_n`. This decouples row-serial producers (attention/FFN output writers) from the tile-parallel GELU array.

---
 rtl/gelu_pkg.sv | 20 ++
 rtl/gelu_row_bank.sv | 29 ++
 rtl/gelu_row_packer.sv | 152 +++++++++++++++
 tb/tb_gelu_row_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gelu_pkg.sv
// Shared types and default sizes for the GELU row packer.
package gelu_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } gelu_state_t;

  localparam int GELU_NUM_DEF  = 128;
  localparam int DIMENTION_DEF = 64;
  localparam int X_WIDTH_DEF   = 8;
  localparam int ROW_W_DEF     = X_WIDTH_DEF * DIMENTION_DEF;

  // Row-index width; a one-row tile still needs a 1-bit index.
  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/gelu_row_bank.sv
// GELU_NUM x row register array: one indexed row write per cycle, whole array read flat.
module gelu_row_bank
  import gelu_pkg::*;
#(
  parameter int ROWS  = GELU_NUM_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int IDX_W = idx_width(ROWS)
) (
  input  logic                    clk_p,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [ROW_W-1:0]        row_in,
  output logic [ROWS*ROW_W-1:0]   rows
);

  logic [ROWS*ROW_W-1:0] mem;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[int'(idx)*ROW_W +: ROW_W] <= row_in;
    end
  end

  assign rows = mem;

endmodule

// File: rtl/gelu_row_packer.sv
// Collects GELU_NUM rows into a tile and hands it to the GELU stage.
// Define GELU_PACK_DBUF_EN for ping/pong banks that keep filling while a tile is in flight.
module gelu_row_packer
  import gelu_pkg::*;
#(
  parameter int GELU_NUM  = GELU_NUM_DEF,
  parameter int DIMENTION = DIMENTION_DEF,
  parameter int x_WIDTH   = X_WIDTH_DEF,
  parameter int CNT_WIDTH = $clog2(GELU_NUM) + 1
) (
  input  logic                                clk_p,
  input  logic                                rst_n,
  input  logic [x_WIDTH*DIMENTION-1:0]        row_in,
  input  logic                                row_valid_n,
  output logic                                row_ready,
  output logic [x_WIDTH*GELU_NUM*DIMENTION-1:0] x,
  output logic                                input_valid_n,
  input  logic                                gelu_valid_n,
  output logic [CNT_WIDTH-1:0]                row_cnt,
  output logic                                busy,
  output gelu_state_t                         state
);

  localparam int ROW_W = x_WIDTH * DIMENTION;
  localparam int IDX_W = idx_width(GELU_NUM);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(GELU_NUM - 1);

  // Handshake: a row transfers on a rising edge where row_valid_n is low and
  // row_ready is high; the producer keeps row_in steady while row_ready is low.
  logic accept;
  assign accept = !row_valid_n && row_ready;

  logic [IDX_W-1:0] wr_idx;
  assign wr_idx = row_cnt[IDX_W-1:0];

`ifdef GELU_PACK_DBUF_EN
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(GELU_NUM);

  logic fill_sel;
  logic issue_sel;
  logic [GELU_NUM*ROW_W-1:0] bank0_rows;
  logic [GELU_NUM*ROW_W-1:0] bank1_rows;

  gelu_row_bank #(.ROWS(GELU_NUM), .ROW_W(ROW_W), .IDX_W(IDX_W)) u_bank0 (
    .clk_p  (clk_p),
    .rst_n  (rst_n),
    .we     (accept && !fill_sel),
    .idx    (wr_idx),
    .row_in (row_in),
    .rows   (bank0_rows)
  );

  gelu_row_bank #(.ROWS(GELU_NUM), .ROW_W(ROW_W), .IDX_W(IDX_W)) u_bank1 (
    .clk_p  (clk_p),
    .rst_n  (rst_n),
    .we     (accept && fill_sel),
    .idx    (wr_idx),
    .row_in (row_in),
    .rows   (bank1_rows)
  );

  // x always follows the most recently issued bank, so it stays put while the other fills.
  assign x = issue_sel ? bank1_rows : bank0_rows;
`else
  logic [GELU_NUM*ROW_W-1:0] bank0_rows;

  gelu_row_bank #(.ROWS(GELU_NUM), .ROW_W(ROW_W), .IDX_W(IDX_W)) u_bank0 (
    .clk_p  (clk_p),
    .rst_n  (rst_n),
    .we     (accept),
    .idx    (wr_idx),
    .row_in (row_in),
    .rows   (bank0_rows)
  );

  assign x = bank0_rows;
`endif

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FILL;
      row_cnt       <= '0;
      row_ready     <= 1'b1;
      input_valid_n <= 1'b1;
      busy          <= 1'b0;
`ifdef GELU_PACK_DBUF_EN
      fill_sel      <= 1'b0;
      issue_sel     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (row_cnt == LAST) begin
              row_cnt       <= '0;
              state         <= ST_ISSUE;
              row_ready     <= 1'b0;
              input_valid_n <= 1'b0;
`ifdef GELU_PACK_DBUF_EN
              issue_sel     <= fill_sel;
              fill_sel      <= ~fill_sel;
`endif
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state         <= ST_WAIT;
          input_valid_n <= 1'b1;
          busy          <= 1'b1;
`ifdef GELU_PACK_DBUF_EN
          row_ready     <= 1'b1;
`endif
        end
        ST_WAIT: begin
`ifdef GELU_PACK_DBUF_EN
          if (!gelu_valid_n) begin
            busy <= 1'b0;
            // A full idle bank (or one completing on this very edge) issues next cycle.
            if (row_cnt == FULL || (accept && row_cnt == LAST)) begin
              row_cnt       <= '0;
              state         <= ST_ISSUE;
              row_ready     <= 1'b0;
              input_valid_n <= 1'b0;
              issue_sel     <= fill_sel;
              fill_sel      <= ~fill_sel;
            end else begin
              state     <= ST_FILL;
              row_ready <= 1'b1;
              if (accept) row_cnt <= row_cnt + 1'b1;
            end
          end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LAST) row_ready <= 1'b0;
          end
`else
          if (!gelu_valid_n) begin
            state     <= ST_FILL;
            busy      <= 1'b0;
            row_ready <= 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gelu_row_packer.sv
// Directed bench for gelu_row_packer with a 4-row, 2-element, 8-bit tile.
module tb_gelu_row_packer;
  import gelu_pkg::*;

  localparam int GN = 4;
  localparam int DM = 2;
  localparam int XW = 8;
  localparam int CW = $clog2(GN) + 1;
`ifdef GELU_PACK_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic              clk_p;
  logic              rst_n;
  logic [XW*DM-1:0]  row_in;
  logic              row_valid_n;
  logic              row_ready;
  logic [XW*GN*DM-1:0] x;
  logic              input_valid_n;
  logic              gelu_valid_n;
  logic [CW-1:0]     row_cnt;
  logic              busy;
  gelu_state_t       state;

  gelu_row_packer #(.GELU_NUM(GN), .DIMENTION(DM), .x_WIDTH(XW), .CNT_WIDTH(CW)) dut (
    .clk_p         (clk_p),
    .rst_n         (rst_n),
    .row_in        (row_in),
    .row_valid_n   (row_valid_n),
    .row_ready     (row_ready),
    .x             (x),
    .input_valid_n (input_valid_n),
    .gelu_valid_n  (gelu_valid_n),
    .row_cnt       (row_cnt),
    .busy          (busy),
    .state         (state)
  );

  // Clock / reset
  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  int total = 0;
  int bad   = 0;
  int issue_cnt = 0;
  int tiles = 0;

  always @(negedge clk_p) if (rst_n && !input_valid_n) issue_cnt++;

  typedef struct {
    logic [3:0][15:0] rows;
    logic [63:0]      exp_x;
    int               hold;
    bit               throttle;
    bit               poke;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one row from the falling edge, leave at posedge+1 after it is taken.
  task automatic send_row(input logic [15:0] d);
    int n = 0;
    @(negedge clk_p);
    row_in = d;
    row_valid_n = 1'b0;
    while (!row_ready && n < 60) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 60) check("send_row_timeout", 64'(row_ready), 64'd1);
    @(posedge clk_p);
    #1;
    row_valid_n = 1'b1;
  endtask

  task automatic complete();
    @(negedge clk_p);
    gelu_valid_n = 1'b0;
    @(posedge clk_p);
    #1;
    gelu_valid_n = 1'b1;
  endtask

  task automatic run_tile(input vec_t v);
    for (int i = 0; i < GN; i++) begin
      if (v.throttle) begin
        int gap = $urandom_range(1, 3);
        for (int k = 0; k < gap; k++) @(negedge clk_p);
      end
      send_row(v.rows[i]);
    end
    check("issue_pulse_low", 64'(input_valid_n), 64'd0);
    check("issue_x", x, v.exp_x);
    check("issue_row_cnt", 64'(row_cnt), 64'd0);
    check("issue_ready", 64'(row_ready), 64'd0);
    @(posedge clk_p);
    #1;
    check("wait_pulse_high", 64'(input_valid_n), 64'd1);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_ready", 64'(row_ready), 64'(DBUF));
    for (int c = 0; c < v.hold; c++) begin
      if (v.poke && !DBUF) begin
        @(negedge clk_p);
        row_in = 16'hDEAD;
        row_valid_n = 1'b0;
      end
      @(posedge clk_p);
      #1;
      check("hold_x", x, v.exp_x);
      check("hold_busy", 64'(busy), 64'd1);
      if (v.poke && !DBUF) check("poke_row_cnt", 64'(row_cnt), 64'd0);
    end
    row_valid_n = 1'b1;
    complete();
    tiles++;
    check("done_busy", 64'(busy), 64'd0);
    check("done_ready", 64'(row_ready), 64'd1);
    check("issue_count", 64'(issue_cnt), 64'(tiles));
  endtask

  initial begin
    vecs[0] = '{rows: {16'h0807, 16'h0605, 16'h0403, 16'h0201},
                exp_x: 64'h0807_0605_0403_0201, hold: 0, throttle: 0, poke: 0};
    vecs[1] = '{rows: {16'h00FE, 16'hFF01, 16'h807F, 16'h7F80},
                exp_x: 64'h00FE_FF01_807F_7F80, hold: 10, throttle: 0, poke: 0};
    vecs[2] = '{rows: {16'h1234, 16'hFFFF, 16'h0000, 16'hA55A},
                exp_x: 64'h1234_FFFF_0000_A55A, hold: 3, throttle: 0, poke: 1};
    vecs[3] = '{rows: {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                exp_x: 64'h4444_3333_2222_1111, hold: 0, throttle: 1, poke: 0};

    rst_n = 1'b0;
    row_in = '0;
    row_valid_n = 1'b1;
    gelu_valid_n = 1'b1;
    #12;
    check("rst_ready", 64'(row_ready), 64'd1);
    check("rst_pulse", 64'(input_valid_n), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_x", x, 64'd0);
    check("rst_row_cnt", 64'(row_cnt), 64'd0);
    @(negedge clk_p);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) run_tile(vecs[t]);

    // Completion while filling is ignored.
    send_row(16'h0A0B);
    @(negedge clk_p);
    gelu_valid_n = 1'b0;
    @(posedge clk_p);
    #1;
    gelu_valid_n = 1'b1;
    check("stray_done_cnt", 64'(row_cnt), 64'd1);
    check("stray_done_state", 64'(state), 64'(ST_FILL));
    check("stray_done_busy", 64'(busy), 64'd0);

    // Reset after two accepted rows discards the partial tile.
    send_row(16'h0C0D);
    check("pre_rst_cnt", 64'(row_cnt), 64'd2);
    @(negedge clk_p);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 64'(row_cnt), 64'd0);
    check("async_rst_x", x, 64'd0);
    check("async_rst_ready", 64'(row_ready), 64'd1);
    @(negedge clk_p);
    rst_n = 1'b1;
    repeat (6) @(posedge clk_p);
    #1;
    check("no_issue_after_rst", 64'(issue_cnt), 64'(tiles));
    run_tile(vecs[0]);

`ifdef GELU_PACK_DBUF_EN
    // Tile A issued, tile B fills the idle bank, completion held off 20 cycles.
    for (int i = 0; i < GN; i++) send_row(16'h1010 + 16'(i));
    tiles++;
    check("a_issue", 64'(input_valid_n), 64'd0);
    for (int i = 0; i < GN; i++) send_row(16'hB000 + 16'(i));
    check("b_stall_cnt", 64'(row_cnt), 64'd4);
    check("b_stall_ready", 64'(row_ready), 64'd0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_p);
      #1;
      check("a_held_x", x, 64'h1013_1012_1011_1010);
    end
    complete();
    tiles++;
    check("b_issue_pulse", 64'(input_valid_n), 64'd0);
    check("b_issue_x", x, 64'hB003_B002_B001_B000);
    check("b_issue_cnt", 64'(row_cnt), 64'd0);
    @(posedge clk_p);
    #1;
    check("b_wait_busy", 64'(busy), 64'd1);
    check("b_wait_ready", 64'(row_ready), 64'd1);
    complete();
    check("b_done_state", 64'(state), 64'(ST_FILL));
    check("b_done_busy", 64'(busy), 64'd0);
    check("b_issue_count", 64'(issue_cnt), 64'(tiles));
`endif

    repeat (3) @(posedge clk_p);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
